oam_dma_ctl: RTL and testbench

- Sprite DMA controller for the NES CPU.
- Detects a CPU write to $4014 and stalls the CPU through its RDY input.
- Takes ownership of the CPU-side bus and copies 256 bytes from page XX00-XXFF into OAM through repeated writes to $2004.
- Sits between the CPU core (address/data/rw outputs and RDY input) and the system bus mux; it is the bus arbiter between CPU and DMA.

---
 rtl/oam_dma_ctl_pkg.sv | 10 +
 rtl/oam_dma_ctl_if.sv | 26 ++
 rtl/oam_dma_ctl.sv | 93 +++++++++
 tb/tb_oam_dma_ctl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_ctl_pkg.sv
// Shared types and default constants for the NES sprite (OAM) DMA controller.
package oam_dma_pkg;

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
   localparam logic        GET_PARITY_DEF    = 1'b0;

endpackage

// File: rtl/oam_dma_ctl_if.sv
// CPU-side and system-bus signals seen by the OAM DMA controller.
interface oam_dma_ctl_if;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_rw;
   logic [7:0]  bus_rdata;
   logic        cpu_rdy;
   logic        dma_sel;
   logic [15:0] bus_addr;
   logic        bus_rw;
   logic [7:0]  bus_wdata;
   logic        dma_busy;
   logic        dma_done;

   modport master (
      input  cpu_addr, cpu_dout, cpu_rw, bus_rdata,
      output cpu_rdy, dma_sel, bus_addr, bus_rw, bus_wdata, dma_busy, dma_done
   );

   modport slave (
      output cpu_addr, cpu_dout, cpu_rw, bus_rdata,
      input  cpu_rdy, dma_sel, bus_addr, bus_rw, bus_wdata, dma_busy, dma_done
   );

endinterface

// File: rtl/oam_dma_ctl.sv
// Sprite DMA: on a CPU write to $4014, halts the CPU and copies page XX00-XXFF
// into OAM via 256 read/write pairs to $2004.
module oam_dma_ctl
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
   parameter logic        GET_PARITY    = GET_PARITY_DEF
) (
   input logic               clk,
   input logic               b_rst,
   oam_dma_ctl_if.master     dma
);

   dma_state_t state_q, state_d;
   logic       par_q;
   logic [7:0] page_q, page_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] latch_q, latch_d;

   always_ff @(posedge clk or negedge b_rst) begin
      if (!b_rst) begin
         state_q <= IDLE;
         par_q   <= 1'b0;
         page_q  <= 8'h00;
         cnt_q   <= 8'h00;
         latch_q <= 8'h00;
      end else begin
         state_q <= state_d;
         par_q   <= ~par_q;
         page_q  <= page_d;
         cnt_q   <= cnt_d;
         latch_q <= latch_d;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      cnt_d   = cnt_q;
      latch_d = latch_q;
      unique case (state_q)
         IDLE: begin
            if (!dma.cpu_rw && (dma.cpu_addr == DMA_REG_ADDR)) begin
               page_d  = dma.cpu_dout;
               cnt_d   = 8'h00;
               state_d = HALT;
            end
         end
         HALT: begin
            // RDY only stalls reads, so pending CPU writes hold us here.
            if (dma.cpu_rw) begin
               state_d = (par_q != GET_PARITY) ? READ : ALIGN;
            end
         end
         ALIGN: state_d = READ;
         READ: begin
            latch_d = dma.bus_rdata;
            state_d = WRITE;
         end
         WRITE: begin
            if (cnt_q == 8'hFF) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dma.cpu_rdy   = (state_q == IDLE);
      dma.dma_busy  = (state_q != IDLE);
      dma.dma_sel   = (state_q == READ) || (state_q == WRITE);
      dma.bus_addr  = 16'h0000;
      dma.bus_rw    = 1'b1;
      dma.bus_wdata = 8'h00;
      dma.dma_done  = 1'b0;
      unique case (state_q)
         READ: dma.bus_addr = {page_q, cnt_q};
         WRITE: begin
            dma.bus_addr  = OAM_DATA_ADDR;
            dma.bus_rw    = 1'b0;
            dma.bus_wdata = latch_q;
            dma.dma_done  = (cnt_q == 8'hFF);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_ctl.sv
// Directed self-checking bench for oam_dma_ctl with a byte-per-address memory model.
module tb_oam_dma_ctl;

   logic clk = 1'b0;
   logic b_rst = 1'b0;
   always #5 clk = ~clk;

   oam_dma_ctl_if dif ();

   oam_dma_ctl u_dut (
      .clk   (clk),
      .b_rst (b_rst),
      .dma   (dif.master)
   );

   // Memory model: each byte holds the low byte of its own address.
   assign dif.bus_rdata = dif.dma_sel ? dif.bus_addr[7:0] : 8'h00;

   int nerr = 0;
   int nchk = 0;

   int ecnt;
   always @(posedge clk or negedge b_rst) begin
      if (!b_rst) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   logic        clr = 1'b0;
   logic [7:0]  page_exp = 8'h00;
   int          stall_n, nosel_n, sel_n, rd_n, wr_n, done_n;
   int          addr_bad, data_bad, zero_n, busy_bad, first_par;
   logic [15:0] last_rd_addr;
   logic [7:0]  rd_idx, last_rdata;

   always @(negedge clk) begin
      if (clr) begin
         stall_n <= 0; nosel_n <= 0; sel_n <= 0; rd_n <= 0; wr_n <= 0; done_n <= 0;
         addr_bad <= 0; data_bad <= 0; zero_n <= 0; busy_bad <= 0; first_par <= -1;
         last_rd_addr <= 16'h0000; rd_idx <= 8'h00; last_rdata <= 8'h00;
      end else begin
         if (!dif.cpu_rdy) stall_n <= stall_n + 1;
         if (!dif.cpu_rdy && !dif.dma_sel) nosel_n <= nosel_n + 1;
         if (dif.dma_sel) sel_n <= sel_n + 1;
         if (dif.dma_busy !== !dif.cpu_rdy) busy_bad <= busy_bad + 1;
         if (dif.dma_sel && dif.bus_addr == 16'h0000) zero_n <= zero_n + 1;
         if (dif.dma_done) done_n <= done_n + 1;
         if (dif.dma_sel && dif.bus_rw) begin
            if (dif.bus_addr !== {page_exp, rd_idx}) addr_bad <= addr_bad + 1;
            if (rd_n == 0) first_par <= ecnt % 2;
            rd_n         <= rd_n + 1;
            rd_idx       <= rd_idx + 8'd1;
            last_rd_addr <= dif.bus_addr;
            last_rdata   <= dif.bus_addr[7:0];
         end
         if (dif.dma_sel && !dif.bus_rw) begin
            if (dif.bus_addr !== 16'h2004 || dif.bus_wdata !== last_rdata)
               data_bad <= data_bad + 1;
            wr_n <= wr_n + 1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   task automatic align_par(input int p);
      for (int i = 0; i < 2; i++) if ((ecnt % 2) != p) cyc();
   endtask

   task automatic trigger(input logic [7:0] pg, input int extra_writes);
      dif.cpu_addr = 16'h4014; dif.cpu_rw = 1'b0; dif.cpu_dout = pg;
      cyc();
      for (int i = 0; i < extra_writes; i++) begin
         dif.cpu_addr = 16'h0300; dif.cpu_rw = 1'b0; dif.cpu_dout = 8'hAA;
         cyc();
      end
      dif.cpu_addr = 16'h8000; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h00;
   endtask

   task automatic wait_done(input string tag);
      logic to;
      to = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if (dif.cpu_rdy) begin
            to = 1'b0;
            break;
         end
         cyc();
      end
      chk(tag, {31'd0, to}, 32'd0);
   endtask

   initial begin
      logic to;
      dif.cpu_addr = 16'h0000; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h00;
      repeat (3) cyc();
      chk("rst_rdy",   dif.cpu_rdy,   1);
      chk("rst_sel",   dif.dma_sel,   0);
      chk("rst_addr",  dif.bus_addr,  0);
      chk("rst_rw",    dif.bus_rw,    1);
      chk("rst_wdata", dif.bus_wdata, 0);
      chk("rst_busy",  dif.dma_busy,  0);
      chk("rst_done",  dif.dma_done,  0);

      // Idle bus, including reads of $4014.
      b_rst = 1'b1;
      clear();
      for (int i = 0; i < 100; i++) begin
         dif.cpu_addr = (i % 10 == 0) ? 16'h4014 : 16'(i);
         dif.cpu_rw   = 1'b1;
         cyc();
      end
      chk("idle_stall", stall_n, 0);
      chk("idle_sel",   sel_n,   0);
      chk("idle_busy",  dif.dma_busy, 0);

      // Halt cycle at par=1: no ALIGN.
      page_exp = 8'h02;
      clear();
      align_par(0);
      trigger(8'h02, 0);
      wait_done("p2_timeout");
      chk("p2_stall", stall_n, 513);
      chk("p2_nosel", nosel_n, 1);
      chk("p2_reads", rd_n, 256);
      chk("p2_writes", wr_n, 256);
      chk("p2_done", done_n, 1);
      chk("p2_addr_bad", addr_bad, 0);
      chk("p2_data_bad", data_bad, 0);
      chk("p2_busy_bad", busy_bad, 0);
      chk("p2_last_rd", last_rd_addr, 16'h02FF);

      // Halt cycle at par=0: one ALIGN cycle.
      clear();
      align_par(1);
      trigger(8'h02, 0);
      wait_done("al_timeout");
      chk("al_stall", stall_n, 514);
      chk("al_nosel", nosel_n, 2);
      chk("al_first_par", first_par, 0);
      chk("al_reads", rd_n, 256);
      chk("al_addr_bad", addr_bad, 0);

      // Two pending CPU writes extend HALT.
      page_exp = 8'h05;
      clear();
      align_par(0);
      trigger(8'h05, 2);
      wait_done("hw_timeout");
      chk("hw_stall", stall_n, 515);
      chk("hw_nosel", nosel_n, 3);
      chk("hw_reads", rd_n, 256);
      chk("hw_data_bad", data_bad, 0);
      chk("hw_addr_bad", addr_bad, 0);

      // Page FF wraps within the page; a mid-transfer $4014 write is ignored.
      page_exp = 8'hFF;
      clear();
      align_par(0);
      trigger(8'hFF, 0);
      repeat (50) cyc();
      dif.cpu_addr = 16'h4014; dif.cpu_rw = 1'b0; dif.cpu_dout = 8'h55;
      cyc();
      dif.cpu_addr = 16'h8000; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h00;
      wait_done("ff_timeout");
      chk("ff_addr_bad", addr_bad, 0);
      chk("ff_zero", zero_n, 0);
      chk("ff_last_rd", last_rd_addr, 16'hFFFF);
      chk("ff_reads", rd_n, 256);
      chk("ff_stall", stall_n, 513);
      chk("ff_done", done_n, 1);
      repeat (5) cyc();
      chk("ff_idle_after", dif.dma_busy, 0);

      // Reset in the middle of a transfer.
      page_exp = 8'h04;
      clear();
      align_par(0);
      trigger(8'h04, 0);
      to = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (rd_n >= 100) begin
            to = 1'b0;
            break;
         end
         cyc();
      end
      chk("mr_timeout", {31'd0, to}, 32'd0);
      b_rst = 1'b0;
      #1;
      chk("mr_rdy",  dif.cpu_rdy,  1);
      chk("mr_sel",  dif.dma_sel,  0);
      chk("mr_busy", dif.dma_busy, 0);
      chk("mr_addr", dif.bus_addr, 0);
      chk("mr_rw",   dif.bus_rw,   1);
      dif.cpu_addr = 16'h4014; dif.cpu_rw = 1'b0; dif.cpu_dout = 8'h09;
      repeat (3) cyc();
      chk("mr_held_busy", dif.dma_busy, 0);
      dif.cpu_addr = 16'h8000; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h00;
      b_rst = 1'b1;
      cyc();
      chk("mr_rel_busy", dif.dma_busy, 0);

      page_exp = 8'h03;
      clear();
      align_par(0);
      trigger(8'h03, 0);
      wait_done("p3_timeout");
      chk("p3_stall", stall_n, 513);
      chk("p3_reads", rd_n, 256);
      chk("p3_addr_bad", addr_bad, 0);
      chk("p3_data_bad", data_bad, 0);
      chk("p3_last_rd", last_rd_addr, 16'h03FF);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
